// File: rtl/reg_to_obi_master_if.sv
// reg_to_obi_master_if: register-interface request/response and OBI initiator
// signals for the reg_to_obi_master bridge.
// The master modport is the bridge's view.
// The slave modport is the environment: the register-bus master plus the OBI responder.
interface reg_to_obi_master_if;
   // register-interface request (held stable by the master from valid to ready)
   logic [31:0] reg_addr;
   logic        reg_write;
   logic [31:0] reg_wdata;
   logic [3:0]  reg_wstrb;
   logic        reg_valid;
   // register-interface response
   logic [31:0] reg_rdata;
   logic        reg_error;
   logic        reg_ready;
   // OBI request
   logic        obi_req;
   logic        obi_we;
   logic [3:0]  obi_be;
   logic [31:0] obi_addr;
   logic [31:0] obi_wdata;
   // OBI response
   logic        obi_gnt;
   logic        obi_rvalid;
   logic [31:0] obi_rdata;

   modport master (
      input  reg_addr, reg_write, reg_wdata, reg_wstrb, reg_valid,
      output reg_rdata, reg_error, reg_ready,
      output obi_req, obi_we, obi_be, obi_addr, obi_wdata,
      input  obi_gnt, obi_rvalid, obi_rdata
   );

   modport slave (
      output reg_addr, reg_write, reg_wdata, reg_wstrb, reg_valid,
      input  reg_rdata, reg_error, reg_ready,
      input  obi_req, obi_we, obi_be, obi_addr, obi_wdata,
      output obi_gnt, obi_rvalid, obi_rdata
   );
endinterface

// File: rtl/reg_to_obi_master.sv
// reg_to_obi_master: bridges a single-outstanding register-interface port onto
// an OBI initiator port. Request fields are captured in IDLE so the OBI payload
// stays stable until grant. The OBI response is returned combinationally on the
// register port.
// Optional feature: define REG_TO_OBI_TIMEOUT_EN to add an rvalid timeout.
// The timeout returns an error response and drops the late rvalid that follows.
module reg_to_obi_master #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   reg_to_obi_master_if.master        bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("reg_to_obi_master: TIMEOUT_CYCLES must lie in 2..65535");
   end

   logic [1:0]  state_q, state_d;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic        we_q;
   logic        accept;
   logic        rsp_ok;
   logic        rsp_timeout;

   assign rsp_ok = (state_q == RESP) && bus.obi_rvalid;

`ifdef REG_TO_OBI_TIMEOUT_EN
   localparam logic [31:0] TIMEOUT_RDATA = 32'hBADC_AB1E;
   logic [15:0] cnt_q;
   logic        stale_q;

   // a timed-out transaction leaves a late rvalid pending; no new request until it drains
   assign accept      = (state_q == IDLE) && bus.reg_valid && !stale_q;
   assign rsp_timeout = (state_q == RESP) && !bus.obi_rvalid &&
                        (cnt_q == 16'(TIMEOUT_CYCLES - 1));

   // response-wait counter and stale-response flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         stale_q <= 1'b0;
      end else begin
         if (state_q == REQ && bus.obi_gnt) begin
            cnt_q <= '0;
         end else if (state_q == RESP && !bus.obi_rvalid) begin
            cnt_q <= cnt_q + 16'd1;
         end
         if (rsp_timeout) begin
            stale_q <= 1'b1;
         end else if (stale_q && bus.obi_rvalid) begin
            stale_q <= 1'b0;
         end
      end
   end
`else
   assign accept      = (state_q == IDLE) && bus.reg_valid;
   assign rsp_timeout = 1'b0;
`endif

   // next-state logic: IDLE -> REQ on capture, REQ -> RESP on grant, RESP -> IDLE on response
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = REQ;
         REQ:     if (bus.obi_gnt) state_d = RESP;
         RESP:    if (rsp_ok || rsp_timeout) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state register and request capture
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q  <= bus.reg_addr;
            wdata_q <= bus.reg_wdata;
            be_q    <= bus.reg_wstrb;
            we_q    <= bus.reg_write;
         end
      end
   end

   // OBI request driven only from the captured registers, zero outside REQ
   always_comb begin
      bus.obi_req   = (state_q == REQ);
      bus.obi_we    = 1'b0;
      bus.obi_be    = '0;
      bus.obi_addr  = '0;
      bus.obi_wdata = '0;
      if (state_q == REQ) begin
         bus.obi_we    = we_q;
         bus.obi_be    = be_q;
         bus.obi_addr  = addr_q;
         bus.obi_wdata = wdata_q;
      end
   end

   // register-port response; rdata reads as zero whenever ready is low
   always_comb begin
      bus.reg_ready = rsp_ok || rsp_timeout;
      bus.reg_error = 1'b0;
      bus.reg_rdata = '0;
      if (rsp_ok) begin
         bus.reg_rdata = bus.obi_rdata;
`ifdef REG_TO_OBI_TIMEOUT_EN
      end else if (rsp_timeout) begin
         bus.reg_rdata = TIMEOUT_RDATA;
         bus.reg_error = 1'b1;
`endif
      end
   end

   // the responder may only raise rvalid while a response is owed
`ifdef REG_TO_OBI_TIMEOUT_EN
   a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
      bus.obi_rvalid |-> (state_q == RESP || stale_q));
`else
   a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
      bus.obi_rvalid |-> (state_q == RESP));
`endif

endmodule
